// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arith ops, bit-serial shifts/rotates and a shift-add multiplier.
module alu_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4,
  parameter int SH_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_WIDTH-1:0]          op,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         zero_f,
  output logic                         neg_f,
  output logic                         pos_f,
  output logic                         carry_f,
  output logic                         ovf_f
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_XOR = 4'h1, OP_OR  = 4'h2, OP_AND = 4'h3,
    OP_SUB = 4'h4, OP_ADD = 4'h5, OP_SRA = 4'h6, OP_SHL = 4'h7,
    OP_ROR = 4'h8, OP_ROL = 4'h9, OP_DEC = 4'hA, OP_INC = 4'hB,
    OP_NOT = 4'hC, OP_LD  = 4'hD, OP_MUL = 4'hE, OP_CMP = 4'hF
  } op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  op_e              op_in, op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     acc_q, mc_q, mp_q, acc_nxt;
  logic [SH_WIDTH-1:0] sh_in;
  logic             accept, go_busy, finish;

  logic [W:0]       sum, diff;
  logic [W-1:0]     inc_v, dec_v, sc_res, sc_fval;
  logic             sc_carry, sc_ovf, sub_ovf;

  // {zero, neg, pos} derived from a flag source value
  function automatic logic [2:0] sign_flags(input logic [W-1:0] v);
    sign_flags = {(v == '0), v[W-1], (v != '0) & ~v[W-1]};
  endfunction

  assign op_in   = op_e'(op);
  assign sh_in   = b[SH_WIDTH-1:0];
  assign accept  = in_valid & in_ready;
  assign go_busy = accept & ((op_in == OP_MUL) ||
                   ((op_in inside {OP_SRA, OP_SHL, OP_ROR, OP_ROL}) && (sh_in != '0)));
  assign finish  = (state_q == BUSY) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_d = go_busy ? BUSY : DONE;
      end
      BUSY: begin
        if (finish) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = accept ? (go_busy ? BUSY : DONE) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Single-cycle datapath, evaluated on the accept edge
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    inc_v    = a + W'(1);
    dec_v    = a - W'(1);
    sub_ovf  = (a[W-1] ^ b[W-1]) & (diff[W-1] ^ a[W-1]);
    sc_res   = a;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (op_in)
      OP_XOR: sc_res = a ^ b;
      OP_OR:  sc_res = a | b;
      OP_AND: sc_res = a & b;
      OP_SUB: begin sc_res = diff[W-1:0]; sc_carry = ~diff[W]; sc_ovf = sub_ovf; end
      OP_ADD: begin
        sc_res   = sum[W-1:0];
        sc_carry = sum[W];
        sc_ovf   = ~(a[W-1] ^ b[W-1]) & (sum[W-1] ^ a[W-1]);
      end
      OP_DEC: begin sc_res = dec_v; sc_carry = |a; sc_ovf = a[W-1] & ~dec_v[W-1]; end
      OP_INC: begin sc_res = inc_v; sc_ovf = ~a[W-1] & inc_v[W-1]; end
      OP_NOT: sc_res = ~a;
      OP_LD:  sc_res = b;
      OP_CMP: begin sc_carry = ~diff[W]; sc_ovf = sub_ovf; end
      default: sc_res = a;
    endcase
    sc_fval = (op_in == OP_CMP) ? diff[W-1:0] : sc_res;
  end

  // One bit-serial step of the op held in BUSY
  always_comb begin
    acc_nxt = acc_q;
    case (op_q)
      OP_SRA:  acc_nxt = {acc_q[W-1], acc_q[W-1:1]};
      OP_SHL:  acc_nxt = {acc_q[W-2:0], 1'b0};
      OP_ROR:  acc_nxt = {acc_q[0], acc_q[W-1:1]};
      OP_ROL:  acc_nxt = {acc_q[W-2:0], acc_q[W-1]};
      OP_MUL:  acc_nxt = mp_q[0] ? acc_q + mc_q : acc_q;
      default: acc_nxt = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (go_busy) begin
      op_q  <= op_in;
      acc_q <= (op_in == OP_MUL) ? '0 : a;
      mc_q  <= a;
      mp_q  <= b;
    end else if (state_q == BUSY) begin
      acc_q <= acc_nxt;
      mc_q  <= {mc_q[W-2:0], 1'b0};
      mp_q  <= {1'b0, mp_q[W-1:1]};
    end
  end

  // Result and flags only change when DONE is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      result  <= '0;
      zero_f  <= 1'b0;
      neg_f   <= 1'b0;
      pos_f   <= 1'b0;
      carry_f <= 1'b0;
      ovf_f   <= 1'b0;
    end else begin
      if (go_busy)
        cnt_q <= (op_in == OP_MUL) ? CNT_W'(W) : CNT_W'(sh_in);
      else if (state_q == BUSY)
        cnt_q <= cnt_q - CNT_W'(1);
      if (accept && !go_busy) begin
        result                 <= sc_res;
        {zero_f, neg_f, pos_f} <= sign_flags(sc_fval);
        carry_f                <= sc_carry;
        ovf_f                  <= sc_ovf;
      end else if (finish) begin
        result                 <= acc_nxt;
        {zero_f, neg_f, pos_f} <= sign_flags(acc_nxt);
        carry_f                <= 1'b0;
        ovf_f                  <= 1'b0;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> $stable(result));
  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(result));

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int W     = 8;
  localparam int MASK  = (1 << W) - 1;
  localparam int SMAX  = (1 << (W - 1)) - 1;
  localparam int SMIN  = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;
  logic         zero_f, neg_f, pos_f, carry_f, ovf_f;

  int n_chk  = 0;
  int n_fail = 0;

  alu_seq #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_f(zero_f), .neg_f(neg_f), .pos_f(pos_f),
    .carry_f(carry_f), .ovf_f(ovf_f)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: result, flags and latency straight from the opcode table
  function automatic void model(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] r, output logic z, output logic n,
                                output logic p, output logic c, output logic v, output int lat);
    int ua, ub, sa, sb, sh, full, fv;
    ua = av; ub = bv; sa = $signed(av); sb = $signed(bv);
    sh = ub % W;
    c = 1'b0; v = 1'b0;
    case (o)
      4'h0: full = ua;
      4'h1: full = ua ^ ub;
      4'h2: full = ua | ub;
      4'h3: full = ua & ub;
      4'h4: begin full = ua - ub; c = (ua >= ub); v = (sa - sb > SMAX) || (sa - sb < SMIN); end
      4'h5: begin full = ua + ub; c = (full > MASK); v = (sa + sb > SMAX) || (sa + sb < SMIN); end
      4'h6: full = sa >>> sh;
      4'h7: full = ua << sh;
      4'h8: full = (ua >> sh) | (ua << (W - sh));
      4'h9: full = (ua << sh) | (ua >> (W - sh));
      4'hA: begin full = ua - 1; c = (ua >= 1); v = (sa - 1 < SMIN); end
      4'hB: begin full = ua + 1; v = (sa + 1 > SMAX); end
      4'hC: full = ~ua;
      4'hD: full = ub;
      4'hE: full = sa * sb;
      default: begin full = ua; c = (ua >= ub); v = (sa - sb > SMAX) || (sa - sb < SMIN); end
    endcase
    full = full & MASK;
    r  = W'(full);
    fv = (o == 4'hF) ? ((ua - ub) & MASK) : full;
    z  = (fv == 0);
    n  = ((fv >> (W - 1)) & 1) != 0;
    p  = !z && !n;
    lat = 1;
    if (o >= 4'h6 && o <= 4'h9 && sh != 0) lat = 1 + sh;
    if (o == 4'hE) lat = 1 + W;
  endfunction

  task automatic expect_out(input string tag, input logic [3:0] o, input logic [W-1:0] av,
                            input logic [W-1:0] bv);
    logic [W-1:0] er;
    logic ez, en, ep, ec, ev;
    int el;
    model(o, av, bv, er, ez, en, ep, ec, ev, el);
    check({tag, ".res"}, result, er);
    check({tag, ".zero"}, zero_f, ez);
    check({tag, ".neg"}, neg_f, en);
    check({tag, ".pos"}, pos_f, ep);
    check({tag, ".carry"}, carry_f, ec);
    check({tag, ".ovf"}, ovf_f, ev);
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int hold);
    logic [W-1:0] er;
    logic ez, en, ep, ec, ev;
    int el, lat;
    model(o, av, bv, er, ez, en, ep, ec, ev, el);
    check({tag, ".in_ready"}, in_ready, 1'b1);
    op = o; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check({tag, ".busy_rdy"}, in_ready, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, lat, el);
    expect_out(tag, o, av, bv);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_vld"}, out_valid, 1'b1);
      check({tag, ".hold_res"}, result, er);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drain"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.result", result, '0);
    check("rst.flags", {zero_f, neg_f, pos_f, carry_f, ovf_f}, 5'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_ovf", 4'h5, 8'h7F, 8'h01, 0);
    run_op("sub_eq",  4'h4, 8'h05, 8'h05, 0);
    run_op("cmp_lt",  4'hF, 8'h03, 8'h07, 1);
    run_op("mul_pos", 4'hE, 8'd13, 8'd11, 0);
    run_op("mul_neg", 4'hE, 8'hFF, 8'h03, 0);
    run_op("rol3",    4'h9, 8'h81, 8'h03, 0);
    run_op("sra2",    4'h6, 8'h90, 8'h02, 0);
    run_op("shl0",    4'h7, 8'hA5, 8'h00, 0);
    run_op("ror7",    4'h8, 8'h01, 8'h07, 0);
    run_op("dec0",    4'hA, 8'h00, 8'h00, 0);
    run_op("dec80",   4'hA, 8'h80, 8'h00, 0);
    run_op("ld",      4'hD, 8'h11, 8'h9C, 0);

    // Backpressure, then back-to-back accept on the take edge
    op = 4'h5; a = 8'h12; b = 8'h34; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.vld", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.in_ready", in_ready, 1'b0);
      check("bp.vld_hold", out_valid, 1'b1);
      expect_out("bp", 4'h5, 8'h12, 8'h34);
    end
    out_ready = 1'b1; op = 4'hB; a = 8'hFF; b = 8'h00; in_valid = 1'b1;
    #1;
    check("b2b.in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b.vld", out_valid, 1'b1);
    expect_out("b2b", 4'hB, 8'hFF, 8'h00);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b.drain", out_valid, 1'b0);

    // Async reset in the middle of a multiply
    op = 4'hE; a = 8'd7; b = 8'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mrst.busy", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst.out_valid", out_valid, 1'b0);
    check("mrst.result", result, '0);
    check("mrst.in_ready", in_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 4'hE, 8'd7, 8'd9, 0);

    for (int i = 0; i < 60; i++) begin
      run_op("rnd", 4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
